data_mem_responder: RTL and testbench

Multi-cycle data-memory responder serving load/store requests issued by the pipeline's memory stage. It accepts one request at a time through a valid/ready handshake and holds the word storage. It returns read data after a fixed, parameterised latency and drives a stall line to the hazard-detection unit while an access is outstanding. It is the responder end of the memory stage's `memRead`/`memWrite` data-memory interface.

---
 rtl/mem_pkg.sv | 15 +
 rtl/data_mem_array.sv | 36 +++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and limits for the data-memory responder.
// Holds the FSM state enum, word size and latency bounds.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int WORD_BYTES = 8;
   localparam int LAT_MIN    = 1;
   localparam int LAT_MAX    = 15;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array: synchronous write, registered read.
// Ports: en_i/we_i gate access, idx_i word index, rdata_o read register.
module data_mem_array #(
   parameter int DATA_W = 64,
   parameter int IDX_W  = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**IDX_W];
   logic [DATA_W-1:0] rdata_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (en_i && we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder for the memory stage.
// Ports: req_* handshake in, rsp_* one-cycle response out, stall to hazard unit.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              stall
);

   localparam int IDX_W    = ADDR_W - 3;
   localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

   if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
      $error("data_mem_responder: LATENCY out of range");
   end
   if (DATA_W != WORD_BYTES * 8) begin : g_bad_w
      $error("data_mem_responder: DATA_W must be 64");
   end

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic              mis_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;

   logic              accept;
   logic              in_mis;
   logic              go_done;
   logic              from_in;
   logic              arr_en;
   logic              arr_we;
   logic [IDX_W-1:0]  arr_idx;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;

   assign accept = (state_q == ST_IDLE) && req_valid;
   assign in_mis = (req_addr[2:0] != 3'd0);

   // With LATENCY==1 the array is hit on the accept edge itself,
   // so it must see the live request instead of the latched one.
   assign from_in = (state_q == ST_IDLE);
   assign go_done = (accept && LATENCY == 1)
                 || (state_q == ST_WAIT && cnt_q == 4'd0);

   assign arr_en    = go_done && !(from_in ? in_mis : mis_q);
   assign arr_we    = from_in ? req_write : wr_q;
   assign arr_idx   = from_in ? req_addr[ADDR_W-1:3] : idx_q;
   assign arr_wdata = from_in ? req_wdata : wdata_q;

   data_mem_array #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .en_i    (arr_en),
      .we_i    (arr_we),
      .idx_i   (arr_idx),
      .wdata_i (arr_wdata),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         mis_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  wr_q    <= req_write;
                  mis_q   <= in_mis;
                  idx_q   <= req_addr[ADDR_W-1:3];
                  wdata_q <= req_wdata;
                  cnt_q   <= 4'(CNT_INIT);
                  state_q <= (LATENCY > 1) ? ST_WAIT : ST_DONE;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_err   = rsp_valid && mis_q;
   assign rsp_rdata = (rsp_valid && !wr_q && !mis_q) ? arr_rdata : '0;
   assign stall     = accept || (state_q == ST_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=3 and LATENCY=1 builds,
// vector table plus hand sequences, scoreboard queues per instance.
module tb_data_mem_responder;

   typedef struct {
      logic        w;
      logic [9:0]  addr;
      logic [63:0] wd;
      logic [63:0] er;
      logic        ee;
   } vec_t;

   typedef struct {
      logic [63:0] rd;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b0, rst_b = 1'b0;
   logic        a_valid = 0, a_write = 0;
   logic [9:0]  a_addr = '0;
   logic [63:0] a_wdata = '0;
   logic        a_ready, a_rvalid, a_err, a_stall;
   logic [63:0] a_rdata;

   logic        b_valid = 0, b_write = 0;
   logic [9:0]  b_addr = '0;
   logic [63:0] b_wdata = '0;
   logic        b_ready, b_rvalid, b_err, b_stall;
   logic [63:0] b_rdata;

   data_mem_responder #(.DATA_W(64), .ADDR_W(10), .LATENCY(3)) dut_a (
      .clock(clk), .reset(rst_a),
      .req_valid(a_valid), .req_write(a_write),
      .req_addr(a_addr), .req_wdata(a_wdata),
      .req_ready(a_ready), .rsp_valid(a_rvalid),
      .rsp_rdata(a_rdata), .rsp_err(a_err), .stall(a_stall)
   );

   data_mem_responder #(.DATA_W(64), .ADDR_W(10), .LATENCY(1)) dut_b (
      .clock(clk), .reset(rst_b),
      .req_valid(b_valid), .req_write(b_write),
      .req_addr(b_addr), .req_wdata(b_wdata),
      .req_ready(b_ready), .rsp_valid(b_rvalid),
      .rsp_rdata(b_rdata), .rsp_err(b_err), .stall(b_stall)
   );

   int n_chk = 0;
   int n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   vec_t tbl[14];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (a_rvalid) begin
         if (qa.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL a_unexpected_rsp: got rsp_valid=1 expected 0");
         end else begin
            ea = qa.pop_front();
            chk("a_rdata", a_rdata, ea.rd);
            chk("a_err", 64'(a_err), 64'(ea.err));
         end
      end
   end

   always @(negedge clk) begin
      if (b_rvalid) begin
         if (qb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL b_unexpected_rsp: got rsp_valid=1 expected 0");
         end else begin
            eb = qb.pop_front();
            chk("b_rdata", b_rdata, eb.rd);
            chk("b_err", 64'(b_err), 64'(eb.err));
         end
      end
   end

   // One LATENCY=3 access with full stall/ready/valid profile.
   task automatic acc_a(input logic w, input logic [9:0] ad,
                        input logic [63:0] wd, input logic [63:0] er,
                        input logic ee, input logic hold);
      exp_t e;
      @(negedge clk);
      a_valid = 1; a_write = w; a_addr = ad; a_wdata = wd;
      e.rd = er; e.err = ee;
      qa.push_back(e);
      #1;
      chk("a_ready_idle", 64'(a_ready), 64'd1);
      chk("a_stall_acc", 64'(a_stall), 64'd1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) a_valid = 0;
         if (k == 4) a_valid = 0;
         #1;
         if (k < 3) begin
            chk("a_stall_wait", 64'(a_stall), 64'd1);
            chk("a_rvalid_wait", 64'(a_rvalid), 64'd0);
            chk("a_ready_wait", 64'(a_ready), 64'd0);
         end else if (k == 3) begin
            chk("a_rvalid_done", 64'(a_rvalid), 64'd1);
            chk("a_stall_done", 64'(a_stall), 64'd0);
            chk("a_ready_done", 64'(a_ready), 64'd0);
         end else begin
            chk("a_ready_back", 64'(a_ready), 64'd1);
            chk("a_rvalid_back", 64'(a_rvalid), 64'd0);
         end
      end
   endtask

   // One LATENCY=1 access; returns in the DONE cycle so the next
   // call issues back-to-back.
   task automatic acc_b(input logic w, input logic [9:0] ad,
                        input logic [63:0] wd, input logic [63:0] er,
                        input logic ee);
      exp_t e;
      @(negedge clk);
      b_valid = 1; b_write = w; b_addr = ad; b_wdata = wd;
      e.rd = er; e.err = ee;
      qb.push_back(e);
      #1;
      chk("b_ready_idle", 64'(b_ready), 64'd1);
      chk("b_stall_acc", 64'(b_stall), 64'd1);
      @(negedge clk);
      b_valid = 0;
      #1;
      chk("b_rvalid_done", 64'(b_rvalid), 64'd1);
      chk("b_stall_done", 64'(b_stall), 64'd0);
      chk("b_ready_done", 64'(b_ready), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 10'h040, 64'hDEADBEEF_01234567, 64'h0, 1'b0};
      tbl[1]  = '{1'b0, 10'h040, 64'h0, 64'hDEADBEEF_01234567, 1'b0};
      tbl[2]  = '{1'b0, 10'h043, 64'h0, 64'h0, 1'b1};
      tbl[3]  = '{1'b0, 10'h040, 64'h0, 64'hDEADBEEF_01234567, 1'b0};
      tbl[4]  = '{1'b1, 10'h045, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
      tbl[5]  = '{1'b0, 10'h040, 64'h0, 64'hDEADBEEF_01234567, 1'b0};
      tbl[6]  = '{1'b1, 10'h3F8, 64'hA5A5_5A5A_A5A5_5A5A, 64'h0, 1'b0};
      tbl[7]  = '{1'b1, 10'h000, 64'h0000_0000_0000_0123, 64'h0, 1'b0};
      tbl[8]  = '{1'b0, 10'h3F8, 64'h0, 64'hA5A5_5A5A_A5A5_5A5A, 1'b0};
      tbl[9]  = '{1'b0, 10'h000, 64'h0, 64'h0000_0000_0000_0123, 1'b0};
      tbl[10] = '{1'b1, 10'h080, 64'h0000_0000_0000_2222, 64'h0, 1'b0};
      tbl[11] = '{1'b0, 10'h080, 64'h0, 64'h0000_0000_0000_2222, 1'b0};
      tbl[12] = '{1'b1, 10'h040, 64'h0000_0000_CAFE_F00D, 64'h0, 1'b0};
      tbl[13] = '{1'b0, 10'h040, 64'h0, 64'h0000_0000_CAFE_F00D, 1'b0};

      #1;
      chk("a_rst_rvalid", 64'(a_rvalid), 64'd0);
      chk("a_rst_rdata", a_rdata, 64'd0);
      repeat (3) @(negedge clk);
      rst_a = 1; rst_b = 1;
      @(negedge clk);
      chk("a_reset_ready", 64'(a_ready), 64'd1);
      chk("b_reset_ready", 64'(b_ready), 64'd1);
      chk("a_reset_stall", 64'(a_stall), 64'd0);

      for (int i = 0; i < 14; i++) begin
         acc_a(tbl[i].w, tbl[i].addr, tbl[i].wd, tbl[i].er, tbl[i].ee, 1'b0);
      end

      // Reset during WAIT of a store: nothing commits.
      @(negedge clk);
      a_valid = 1; a_write = 1; a_addr = 10'h080;
      a_wdata = 64'h0000_0000_0000_1111;
      @(negedge clk);
      a_valid = 0;
      #2;
      rst_a = 0;
      #1;
      chk("a_mid_rst_rvalid", 64'(a_rvalid), 64'd0);
      chk("a_mid_rst_rdata", a_rdata, 64'd0);
      chk("a_mid_rst_err", 64'(a_err), 64'd0);
      chk("a_mid_rst_stall", 64'(a_stall), 64'd0);
      repeat (2) @(negedge clk);
      rst_a = 1;
      #1;
      chk("a_post_rst_ready", 64'(a_ready), 64'd1);
      repeat (4) @(negedge clk);
      acc_a(1'b0, 10'h080, 64'h0, 64'h0000_0000_0000_2222, 1'b0, 1'b0);

      // Held request: one pulse only, no re-accept before IDLE.
      acc_a(1'b1, 10'h0C0, 64'h0000_0000_0000_7777, 64'h0, 1'b0, 1'b1);
      repeat (6) @(negedge clk);
      acc_a(1'b0, 10'h0C0, 64'h0, 64'h0000_0000_0000_7777, 1'b0, 1'b1);
      repeat (6) @(negedge clk);

      // LATENCY=1 back-to-back traffic.
      acc_b(1'b1, 10'h100, 64'h0000_0000_0000_00A1, 64'h0, 1'b0);
      acc_b(1'b1, 10'h100, 64'h0000_0000_0000_00B2, 64'h0, 1'b0);
      acc_b(1'b0, 10'h100, 64'h0, 64'h0000_0000_0000_00B2, 1'b0);
      acc_b(1'b1, 10'h108, 64'h0000_0000_0000_00C3, 64'h0, 1'b0);
      acc_b(1'b0, 10'h108, 64'h0, 64'h0000_0000_0000_00C3, 1'b0);
      acc_b(1'b0, 10'h100, 64'h0, 64'h0000_0000_0000_00B2, 1'b0);
      acc_b(1'b0, 10'h101, 64'h0, 64'h0, 1'b1);
      @(negedge clk);
      #1;
      chk("b_ready_end", 64'(b_ready), 64'd1);

      for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) begin
         @(negedge clk);
      end
      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
